// File: rtl/rv_muldiv_arb_pkg.sv
// Shared types for the muldiv arbiter: ALU op encoding, sequencer states and
// the divide-by-zero result helper.
package rv_muldiv_arb_pkg;

   typedef enum logic [3:0] {
      ALU_NONE   = 4'h0,
      ALU_MUL    = 4'h8,
      ALU_MULH   = 4'h9,
      ALU_MULHSU = 4'hA,
      ALU_MULHU  = 4'hB,
      ALU_DIV    = 4'hC,
      ALU_DIVU   = 4'hD,
      ALU_REM    = 4'hE,
      ALU_REMU   = 4'hF
   } alu_t;

   typedef enum logic [2:0] {S_IDLE, S_MUL_W, S_DIV_R, S_DIV_C, S_RESP} state_t;

   localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

   function automatic logic is_div(alu_t op);
      return op[3] & op[2];
   endfunction

   // RISC-V defines x/0: quotient all ones, remainder the dividend.
   function automatic logic [31:0] dz_result(alu_t op, logic [31:0] dividend);
      return op[1] ? dividend : DZ_QUOT;
   endfunction

endpackage

// File: rtl/rv_muldiv_arb_if.sv
// Requester, response and muldiv-unit signals of the arbiter.
// slave is the arbiter's view, master the surrounding pipeline/unit view.
interface rv_muldiv_arb_if #(
   parameter int NREQ = 2,
   parameter int TAGW = 5
);
   import rv_muldiv_arb_pkg::*;

   logic [NREQ-1:0]             req_valid;
   logic [NREQ-1:0]             req_ready;
   alu_t [NREQ-1:0]             req_alu;
   logic [NREQ-1:0][31:0]       req_a;
   logic [NREQ-1:0][31:0]       req_b;
   logic [NREQ-1:0][TAGW-1:0]   req_tag;

   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [$clog2(NREQ)-1:0]     rsp_id;
   logic [TAGW-1:0]             rsp_tag;
   logic [31:0]                 rsp_data;

   alu_t                        md_alu;
   logic [31:0]                 md_rrd1;
   logic [31:0]                 md_rrd2;
   logic                        md_rdy;
   logic [31:0]                 md_rwdat;
   logic [31:0]                 md_rwdatx;
   logic                        md_cmpl;

   modport slave (
      input  req_valid, req_alu, req_a, req_b, req_tag, rsp_ready,
             md_rwdat, md_rwdatx, md_cmpl,
      output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_data,
             md_alu, md_rrd1, md_rrd2, md_rdy
   );

   modport master (
      output req_valid, req_alu, req_a, req_b, req_tag, rsp_ready,
             md_rwdat, md_rwdatx, md_cmpl,
      input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_data,
             md_alu, md_rrd1, md_rrd2, md_rdy
   );

endinterface

// File: rtl/rv_rr_arb.sv
// Round-robin grant over NREQ requesters; the search starts at r_ptr and the
// pointer moves past the winner only when i_adv confirms the grant was used.
module rv_rr_arb #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_adv,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   logic [IDW-1:0] r_ptr;

   always_comb begin
      logic [IDW-1:0] w_j;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = IDW'((int'(r_ptr) + k) % NREQ);
         if (!o_any && i_req[w_j]) begin
            o_any = 1'b1;
            o_idx = w_j;
            o_gnt = NREQ'(1) << w_j;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (i_adv)
         r_ptr <= (o_idx == IDW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
   end

endmodule

// File: rtl/rv_muldiv_arb.sv
// Shares one rv_muldiv unit between NREQ requesters: round-robin issue, holds
// the unit inputs for the whole op, returns the tagged result.
module rv_muldiv_arb
   import rv_muldiv_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int TAGW = 5
) (
   input  logic           clk,
   input  logic           reset,
   rv_muldiv_arb_if.slave bus,
   output logic           busy
);

   localparam int IDW = $clog2(NREQ);

   state_t          r_state, w_next;
   alu_t            r_alu;
   logic [31:0]     r_a, r_b, r_data;
   logic [TAGW-1:0] r_tag;
   logic [IDW-1:0]  r_id;

   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic            w_any, w_issue, w_div, w_dz;
   alu_t            w_alu;
   logic [31:0]     w_a, w_b;

   rv_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk   (clk),
      .reset (reset),
      .i_req (bus.req_valid),
      .i_adv (w_issue),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_issue = (r_state == S_IDLE) && w_any;
   assign w_alu   = bus.req_alu[w_idx];
   assign w_a     = bus.req_a[w_idx];
   assign w_b     = bus.req_b[w_idx];
   assign w_div   = is_div(w_alu);
   assign w_dz    = w_div && (w_b == 32'd0);

   assign bus.req_ready = w_issue ? w_gnt : '0;
   assign bus.md_rdy    = w_issue && w_div && !w_dz;

   // The divider samples its inputs every cycle until it completes, so the op
   // registers keep driving them right through DIV_C.
   always_comb begin
      bus.md_alu  = r_alu;
      bus.md_rrd1 = r_a;
      bus.md_rrd2 = r_b;
      if (w_issue) begin
         bus.md_alu  = w_alu;
         bus.md_rrd1 = w_a;
         bus.md_rrd2 = w_b;
      end else if (r_state == S_IDLE || r_state == S_RESP) begin
         bus.md_alu  = ALU_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_issue) w_next = w_dz ? S_RESP : (w_div ? S_DIV_R : S_MUL_W);
         S_MUL_W: w_next = S_RESP;
         S_DIV_R: if (bus.md_cmpl) w_next = S_DIV_C;
         S_DIV_C: w_next = S_RESP;
         S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu  <= ALU_NONE;
         r_a    <= '0;
         r_b    <= '0;
         r_tag  <= '0;
         r_id   <= '0;
         r_data <= '0;
      end else begin
         if (w_issue) begin
            r_alu <= w_alu;
            r_a   <= w_a;
            r_b   <= w_b;
            r_tag <= bus.req_tag[w_idx];
            r_id  <= w_idx;
            if (w_dz) r_data <= dz_result(w_alu, w_a);
         end
         if (r_state == S_MUL_W) r_data <= bus.md_rwdatx;
         if (r_state == S_DIV_C) r_data <= bus.md_rwdat;
      end
   end

   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_id    = r_id;
   assign bus.rsp_tag   = r_tag;
   assign bus.rsp_data  = r_data;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_rv_muldiv_arb.sv
// Bench for rv_muldiv_arb: behavioural muldiv unit, vector table, scoreboard,
// and hand-written round-robin, back-pressure and mid-divide reset sequences.
module tb_rv_muldiv_arb;
   import rv_muldiv_arb_pkg::*;

   localparam int NREQ = 2;
   localparam int TAGW = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy;
   int   cyc = 0;

   rv_muldiv_arb_if #(.NREQ(NREQ), .TAGW(TAGW)) mif();

   rv_muldiv_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              id;
      logic [TAGW-1:0] tag;
      logic [31:0]     data;
   } rsp_t;

   typedef struct {
      int              rq;
      alu_t            op;
      logic [31:0]     a;
      logic [31:0]     b;
      logic [TAGW-1:0] tag;
      logic [31:0]     exp;
      int              lat;
   } vec_t;

   rsp_t sb_q[$];
   vec_t vt[12];
   int   checks = 0;
   int   errors = 0;
   int   rdy_total = 0;
   int   stab_err = 0;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---- behavioural rv_muldiv unit ----
   function automatic logic [31:0] mul_ref(alu_t op, logic [31:0] a, logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = {32'b0, a};
      eb = {32'b0, b};
      if (op == ALU_MULH || op == ALU_MULHSU) ea = {{32{a[31]}}, a};
      if (op == ALU_MULH) eb = {{32{b[31]}}, b};
      p = ea * eb;
      return (op == ALU_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] div_ref(alu_t op, logic [31:0] a, logic [31:0] b);
      logic        sg;
      logic [31:0] q, r;
      if (b == 32'd0) return 32'd0;
      sg = (op == ALU_DIV || op == ALU_REM);
      if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
      end else if (sg) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return (op == ALU_REM || op == ALU_REMU) ? r : q;
   endfunction

   logic [31:0] x_res;
   int          dcnt = 0;
   alu_t        s_alu;
   logic [31:0] s_a, s_b;

   always @(posedge clk) begin
      if (reset) begin
         x_res <= '0;
         dcnt  <= 0;
      end else begin
         x_res <= mul_ref(mif.md_alu, mif.md_rrd1, mif.md_rrd2);
         if (mif.md_rdy) begin
            dcnt  <= 1;
            s_alu <= mif.md_alu;
            s_a   <= mif.md_rrd1;
            s_b   <= mif.md_rrd2;
         end else if (dcnt != 0) begin
            dcnt  <= (dcnt >= 17) ? 0 : dcnt + 1;
         end
      end
   end

   assign mif.md_rwdatx = x_res;
   assign mif.md_cmpl   = (dcnt == 16);
   assign mif.md_rwdat  = div_ref(mif.md_alu, mif.md_rrd1, mif.md_rrd2);

   // ---- monitor: operand hold, md_rdy count, response scoreboard ----
   initial forever begin
      rsp_t e;
      @(negedge clk);
      if (mif.md_rdy === 1'b1) rdy_total++;
      if (dcnt != 0 && (mif.md_alu !== s_alu || mif.md_rrd1 !== s_a || mif.md_rrd2 !== s_b))
         stab_err++;
      if (mif.rsp_valid === 1'b1 && mif.rsp_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rsp", 1'b0, mif.rsp_data, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("rsp_id", int'(mif.rsp_id) == e.id, 32'(mif.rsp_id), 32'(e.id));
            check("rsp_tag", mif.rsp_tag == e.tag, 32'(mif.rsp_tag), 32'(e.tag));
            check("rsp_data", mif.rsp_data == e.data, mif.rsp_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---- stimulus helpers ----
   task automatic do_reset();
      reset = 1'b1;
      mif.req_valid = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb_q.size() == 0, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic run_op(input vec_t v);
      int   n, r0, s0;
      rsp_t e;
      @(posedge clk);
      #1;
      mif.req_valid[v.rq] = 1'b1;
      mif.req_alu[v.rq]   = v.op;
      mif.req_a[v.rq]     = v.a;
      mif.req_b[v.rq]     = v.b;
      mif.req_tag[v.rq]   = v.tag;
      r0 = rdy_total;
      s0 = stab_err;
      n  = 0;
      @(negedge clk);
      while (mif.req_ready[v.rq] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("grant_wait", n == 0, 32'(n), 32'd0);
      if (n >= 20) begin
         mif.req_valid[v.rq] = 1'b0;
         return;
      end
      e.id = v.rq; e.tag = v.tag; e.data = v.exp;
      sb_q.push_back(e);
      @(posedge clk);
      #1 mif.req_valid[v.rq] = 1'b0;
      n = 1;
      @(negedge clk);
      while (mif.rsp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", n == v.lat, 32'(n), 32'(v.lat));
      check("md_rdy_pulses", (rdy_total - r0) == ((v.lat == 18) ? 1 : 0),
            32'(rdy_total - r0), (v.lat == 18) ? 32'd1 : 32'd0);
      check("operand_hold", stab_err == s0, 32'(stab_err - s0), 32'd0);
   endtask

   // ---- main sequence ----
   initial begin
      int   n, idx, last, nresp;
      rsp_t e;
      logic [31:0]     d0;
      logic [TAGW-1:0] t0;

      mif.req_valid = '0;
      mif.req_alu   = '{default: ALU_NONE};
      mif.req_a     = '0;
      mif.req_b     = '0;
      mif.req_tag   = '0;
      mif.rsp_ready = 1'b1;

      vt[0]  = '{0, ALU_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 5'd1,  32'h242D_2080, 2};
      vt[1]  = '{1, ALU_DIV,    32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFD, 18};
      vt[2]  = '{1, ALU_REM,    32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFF, 18};
      vt[3]  = '{0, ALU_DIVU,   32'd100,       32'd0,         5'd4,  32'hFFFF_FFFF, 1};
      vt[4]  = '{0, ALU_REM,    32'd100,       32'd0,         5'd5,  32'd100,       1};
      vt[5]  = '{1, ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000, 18};
      vt[6]  = '{0, ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 2};
      vt[7]  = '{1, ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 2};
      vt[8]  = '{0, ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'hFFFF_FFFF, 2};
      vt[9]  = '{1, ALU_REMU,   32'd100,       32'd7,         5'd10, 32'd2,         18};
      vt[10] = '{0, ALU_DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        18};
      vt[11] = '{1, ALU_REMU,   32'd5,         32'd0,         5'd12, 32'd5,         1};

      do_reset();
      @(negedge clk);
      check("rst_busy",      busy == 1'b0,            32'(busy), 32'd0);
      check("rst_rsp_valid", mif.rsp_valid == 1'b0,   32'(mif.rsp_valid), 32'd0);
      check("rst_req_ready", mif.req_ready == '0,     32'(mif.req_ready), 32'd0);
      check("rst_md_rdy",    mif.md_rdy == 1'b0,      32'(mif.md_rdy), 32'd0);
      check("rst_md_alu",    mif.md_alu == ALU_NONE,  32'(mif.md_alu), 32'(ALU_NONE));
      check("rst_rsp_data",  mif.rsp_data == 32'd0,   mif.rsp_data, 32'd0);

      foreach (vt[i]) run_op(vt[i]);
      drain();

      // Both requesters always valid: alternating grants, one op per 3 cycles.
      do_reset();
      mif.req_alu[0] = ALU_MULHU; mif.req_a[0] = 32'hFFFF_FFFF; mif.req_b[0] = 32'hFFFF_FFFF; mif.req_tag[0] = 5'd3;
      mif.req_alu[1] = ALU_MULHU; mif.req_a[1] = 32'h8000_0000; mif.req_b[1] = 32'd4;         mif.req_tag[1] = 5'd17;
      mif.req_valid  = 2'b11;
      last = 0;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         @(negedge clk);
         while (mif.req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("rr_onehot", $onehot(mif.req_ready), 32'(mif.req_ready), 32'd1);
         idx = mif.req_ready[1] ? 1 : 0;
         check("rr_order", idx == g % 2, 32'(idx), 32'(g % 2));
         if (g > 0) check("mul_tput", cyc - last == 3, 32'(cyc - last), 32'd3);
         last = cyc;
         e.id = idx;
         e.tag = (idx == 1) ? 5'd17 : 5'd3;
         e.data = (idx == 1) ? 32'd2 : 32'hFFFF_FFFE;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1 mif.req_valid = '0;
      drain();

      // Back-pressure: response held, competing request must not be granted.
      @(posedge clk);
      #1;
      mif.rsp_ready = 1'b0;
      mif.req_alu[0] = ALU_MUL; mif.req_a[0] = 32'd7; mif.req_b[0] = 32'd6; mif.req_tag[0] = 5'd21;
      mif.req_valid[0] = 1'b1;
      n = 0;
      @(negedge clk);
      while (mif.req_ready[0] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      e.id = 0; e.tag = 5'd21; e.data = 32'd42;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      mif.req_valid[0] = 1'b0;
      mif.req_alu[1] = ALU_MUL; mif.req_a[1] = 32'd3; mif.req_b[1] = 32'd5; mif.req_tag[1] = 5'd22;
      mif.req_valid[1] = 1'b1;
      n = 0;
      @(negedge clk);
      while (mif.rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      d0 = mif.rsp_data;
      t0 = mif.rsp_tag;
      check("stall_data", d0 == 32'd42, d0, 32'd42);
      check("stall_no_grant0", mif.req_ready == '0, 32'(mif.req_ready), 32'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_valid", mif.rsp_valid == 1'b1, 32'(mif.rsp_valid), 32'd1);
         check("stall_data_hold", mif.rsp_data == d0, mif.rsp_data, d0);
         check("stall_tag_hold", mif.rsp_tag == t0, 32'(mif.rsp_tag), 32'(t0));
         check("stall_no_grant", mif.req_ready == '0, 32'(mif.req_ready), 32'd0);
      end
      @(posedge clk);
      #1 mif.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("regrant_next_cycle", mif.req_ready == 2'b10, 32'(mif.req_ready), 32'd2);
      e.id = 1; e.tag = 5'd22; e.data = 32'd15;
      sb_q.push_back(e);
      @(posedge clk);
      #1 mif.req_valid[1] = 1'b0;
      drain();

      // Reset in the middle of a divide: op is dropped without a response.
      @(posedge clk);
      #1;
      mif.req_alu[1] = ALU_DIV; mif.req_a[1] = 32'hFFFF_FFF9; mif.req_b[1] = 32'd2; mif.req_tag[1] = 5'd9;
      mif.req_valid[1] = 1'b1;
      n = 0;
      @(negedge clk);
      while (mif.req_ready[1] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_div_grant", n < 20, 32'(n), 32'd0);
      @(posedge clk);
      #1 mif.req_valid[1] = 1'b0;
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("div_busy_T8", busy == 1'b1, 32'(busy), 32'd1);
      check("div_alu_T8", mif.md_alu == ALU_DIV, 32'(mif.md_alu), 32'(ALU_DIV));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_valid", mif.rsp_valid == 1'b0, 32'(mif.rsp_valid), 32'd0);
      check("post_rst_busy", busy == 1'b0, 32'(busy), 32'd0);
      nresp = 0;
      repeat (25) begin
         @(negedge clk);
         if (mif.rsp_valid === 1'b1) nresp++;
      end
      check("no_dropped_rsp", nresp == 0, 32'(nresp), 32'd0);
      run_op('{0, ALU_MUL, 32'd9, 32'd11, 5'd30, 32'd99, 2});
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
